// File: rtl/dino_pkg.sv
// Shared encodings for the dino vertical-motion engine.
// Game states, pose encodings and a small width helper.
package dino_pkg;

  localparam logic [1:0] GS_UNBEGIN = 2'b00;
  localparam logic [1:0] GS_RUNNING = 2'b01;
  localparam logic [1:0] GS_DEAD    = 2'b10;

  typedef enum logic [1:0] {
    POSE_GROUND = 2'b00,
    POSE_DUCK   = 2'b01,
    POSE_AIR    = 2'b10,
    POSE_DEAD   = 2'b11
  } pose_t;

  function automatic int dmax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dino_jump_buffer.sv
// Jump press edge detector with a tick-based hold window.
// A press stays pending for JUMP_BUF frame ticks unless consumed.
module dino_jump_buffer #(
  parameter int JUMP_BUF = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic jump,
  input  logic consume,
  output logic pending
);

  localparam int CW = (JUMP_BUF < 1) ? 1 : $clog2(JUMP_BUF + 1);

  logic          jump_q;
  logic [CW-1:0] cnt_q;
  logic          rise;

  assign rise    = jump & ~jump_q;
  assign pending = rise | (cnt_q != '0);

  // edge history and pending-window countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      jump_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      jump_q <= jump;
      if (consume) begin
        cnt_q <= '0;
      end else if (rise) begin
        cnt_q <= tick ? CW'(JUMP_BUF - 1) : CW'(JUMP_BUF);
      end else if (tick && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/dino_motion_ctrl.sv
// Dino vertical-motion engine: jumps, double jump, fast-fall,
// landing detection and ceiling clamp, advanced on the frame tick.
module dino_motion_ctrl #(
  parameter int Y_W        = 10,
  parameter int V_W        = 8,
  parameter int GROUND_Y   = 102,
  parameter int START_X    = 10,
  parameter int Y_MAX      = 479,
  parameter int JUMP_V     = 40,
  parameter int GRAV       = 4,
  parameter int FAST_GRAV  = 12,
  parameter int V_MAX_FALL = 60,
  parameter int MAX_JUMPS  = 2,
  parameter int JUMP_BUF   = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               tick,
  input  logic                               jump,
  input  logic                               lying,
  input  logic [1:0]                         gamestate,
  output logic [9:0]                         dino_x,
  output logic [Y_W-1:0]                     dino_y,
  output logic signed [V_W-1:0]              vel,
  output logic [1:0]                         pose,
  output logic [$clog2(MAX_JUMPS+1)-1:0]     jumps_used,
  output logic                               landed
);

  import dino_pkg::*;

  localparam int JW = $clog2(MAX_JUMPS + 1);
  localparam int SW = dmax(Y_W, V_W) + 2;

  localparam logic [Y_W-1:0]        GY     = Y_W'(GROUND_Y);
  localparam logic [Y_W-1:0]        YM     = Y_W'(Y_MAX);
  localparam logic signed [V_W-1:0] JV     = V_W'(JUMP_V);
  localparam logic signed [V_W-1:0] VMIN_V = V_W'(-V_MAX_FALL);
  localparam logic signed [SW-1:0]  GND_S  = SW'(GROUND_Y);
  localparam logic signed [SW-1:0]  YMAX_S = SW'(Y_MAX);
  localparam logic signed [SW-1:0]  VMIN_S = SW'(-V_MAX_FALL);
  localparam logic signed [SW-1:0]  G_S    = SW'(GRAV);
  localparam logic signed [SW-1:0]  FG_S   = SW'(FAST_GRAV);
  localparam logic [JW-1:0]         MAXJ   = JW'(MAX_JUMPS);

  logic [Y_W-1:0]        y_q, y_d;
  logic signed [V_W-1:0] vel_q, vel_d;
  pose_t                 pose_q, pose_d;
  logic [JW-1:0]         ju_q, ju_d;
  logic                  landed_q, landed_d;

  logic                  pending;
  logic                  consume;
  logic                  launch;
  logic                  gs_run;
  logic                  gs_dead;
  logic                  airborne;
  logic                  rising;

  logic signed [SW-1:0]  y_s;
  logic signed [SW-1:0]  v_s;
  logic signed [SW-1:0]  g_s;
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  vdec;

  assign gs_run  = (gamestate == GS_RUNNING);
  assign gs_dead = (gamestate == GS_DEAD);

  // a dino frozen mid-air by Dead resumes falling if play restarts
  assign airborne = (pose_q == POSE_AIR) ||
                    ((pose_q == POSE_DEAD) && (y_q != GY));

  assign rising = !vel_q[V_W-1] && (vel_q != '0);

  assign y_s  = $signed({{(SW-Y_W){1'b0}}, y_q});
  assign v_s  = $signed({{(SW-V_W){vel_q[V_W-1]}}, vel_q});
  assign g_s  = lying ? FG_S : G_S;
  assign sum  = y_s + v_s;
  assign vdec = v_s - g_s;

  // non-running ticks also flush any buffered press
  assign consume = tick & (~gs_run | launch);

  dino_jump_buffer #(
    .JUMP_BUF (JUMP_BUF)
  ) u_jbuf (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .jump    (jump),
    .consume (consume),
    .pending (pending)
  );

  // motion state register
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= GY;
      vel_q    <= '0;
      pose_q   <= POSE_GROUND;
      ju_q     <= '0;
      landed_q <= 1'b0;
    end else begin
      y_q      <= y_d;
      vel_q    <= vel_d;
      pose_q   <= pose_d;
      ju_q     <= ju_d;
      landed_q <= landed_d;
    end
  end

  // per-tick pose transitions and physics step
  always_comb begin
    y_d      = y_q;
    vel_d    = vel_q;
    pose_d   = pose_q;
    ju_d     = ju_q;
    landed_d = 1'b0;
    launch   = 1'b0;
    if (tick) begin
      unique case (1'b1)
        gs_dead: begin
          pose_d = POSE_DEAD;
        end
        gs_run: begin
          if (!airborne) begin
            if (pending) begin
              pose_d = POSE_AIR;
              vel_d  = JV;
              ju_d   = JW'(1);
              launch = 1'b1;
            end else begin
              pose_d = lying ? POSE_DUCK : POSE_GROUND;
            end
          end else if (pending && (ju_q < MAXJ)) begin
            pose_d = POSE_AIR;
            vel_d  = JV;
            ju_d   = ju_q + JW'(1);
            launch = 1'b1;
          end else begin
            pose_d = POSE_AIR;
            if (sum <= GND_S) begin
              y_d      = GY;
              vel_d    = '0;
              pose_d   = lying ? POSE_DUCK : POSE_GROUND;
              ju_d     = '0;
              landed_d = 1'b1;
            end else if ((sum >= YMAX_S) && rising) begin
              // clamp only while rising so a stall at Y_MAX still falls
              y_d   = YM;
              vel_d = '0;
            end else begin
              y_d   = sum[Y_W-1:0];
              vel_d = (vdec < VMIN_S) ? VMIN_V : vdec[V_W-1:0];
            end
          end
        end
        default: begin
          y_d    = GY;
          vel_d  = '0;
          pose_d = POSE_GROUND;
          ju_d   = '0;
        end
      endcase
    end
  end

  assign dino_x     = 10'(START_X);
  assign dino_y     = y_q;
  assign vel        = vel_q;
  assign pose       = pose_q;
  assign jumps_used = ju_q;
  assign landed     = landed_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Scoreboard bench for dino_motion_ctrl.
// Stimulus pushes per-tick expectations; a monitor pops and checks.
module tb_dino_motion_ctrl;

  typedef struct {
    string n;
    int    y;
    int    v;
    int    p;
    int    j;
    int    l;
    int    m;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic              jump;
  logic              lying;
  logic [1:0]        gamestate;

  logic [9:0]        dino_x;
  logic [9:0]        dino_y;
  logic signed [7:0] vel;
  logic [1:0]        pose;
  logic [1:0]        jumps_used;
  logic              landed;

  logic [9:0]        dino_x1;
  logic [9:0]        dino_y1;
  logic signed [9:0] vel1;
  logic [1:0]        pose1;
  logic [1:0]        jumps_used1;
  logic              landed1;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  dino_motion_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .jump       (jump),
    .lying      (lying),
    .gamestate  (gamestate),
    .dino_x     (dino_x),
    .dino_y     (dino_y),
    .vel        (vel),
    .pose       (pose),
    .jumps_used (jumps_used),
    .landed     (landed)
  );

  dino_motion_ctrl #(
    .V_W    (10),
    .JUMP_V (200),
    .Y_MAX  (300)
  ) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .jump       (jump),
    .lying      (lying),
    .gamestate  (gamestate),
    .dino_x     (dino_x1),
    .dino_y     (dino_y1),
    .vel        (vel1),
    .pose       (pose1),
    .jumps_used (jumps_used1),
    .landed     (landed1)
  );

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input string n, input int y, input int v,
                              input int p, input int j, input int l,
                              input int m = 31);
    exp_t e;
    e.n = n; e.y = y; e.v = v; e.p = p;
    e.j = j; e.l = l; e.m = m;
    return e;
  endfunction

  task automatic tk(input exp_t e);
    sb.push_back(e);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic press();
    jump = 1'b1;
    @(negedge clk);
    jump = 1'b0;
    @(negedge clk);
  endtask

  function automatic int rise_y(input int k);
    return 102 + 40 * k - 2 * k * (k - 1);
  endfunction

  // monitor: every tick the DUT presents a new motion state
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      if (tick && !rst) begin
        #1;
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          ex = sb.pop_front();
          if (ex.m[0]) chk({ex.n, ".y"}, int'(dino_y), ex.y);
          if (ex.m[1]) chk({ex.n, ".vel"}, int'(vel), ex.v);
          if (ex.m[2]) chk({ex.n, ".pose"}, int'(pose), ex.p);
          if (ex.m[3]) chk({ex.n, ".jumps"}, int'(jumps_used), ex.j);
          if (ex.m[4]) chk({ex.n, ".landed"}, int'(landed), ex.l);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; jump = 1'b0;
    lying = 1'b0; gamestate = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst.x", int'(dino_x), 10);
    chk("rst.y", int'(dino_y), 102);
    chk("rst.vel", int'(vel), 0);
    chk("rst.pose", int'(pose), 0);
    chk("rst.jumps", int'(jumps_used), 0);
    chk("rst.landed", int'(landed), 0);
    rst = 1'b0;
    @(negedge clk);
    tk(mk("unbegin", 102, 0, 0, 0, 0));

    // single jump, apex, landing
    gamestate = 2'b01;
    @(negedge clk);
    press();
    tk(mk("t1.launch", 102, 40, 2, 1, 0));
    for (int k = 1; k <= 20; k++)
      tk(mk($sformatf("t1.k%0d", k), rise_y(k), 40 - 4 * k, 2, 1, 0));
    tk(mk("t1.land", 102, 0, 0, 0, 1));
    @(posedge clk);
    #1;
    chk("t1.landed_off", int'(landed), 0);
    @(negedge clk);

    // double jump, ceiling, buffered press fires on landing
    press();
    tk(mk("t2.launch", 102, 40, 2, 1, 0));
    for (int k = 1; k <= 10; k++)
      tk(mk($sformatf("t2.k%0d", k), rise_y(k), 40 - 4 * k, 2, 1, 0));
    press();
    tk(mk("t2.dbl", 322, 40, 2, 2, 0));
    press();
    tk(mk("t2.limit", 362, 36, 2, 2, 0));
    tk(mk("t2.r2", 398, 32, 2, 2, 0));
    tk(mk("t2.r3", 430, 28, 2, 2, 0));
    tk(mk("t2.r4", 458, 24, 2, 2, 0));
    tk(mk("t2.ceil", 479, 0, 2, 2, 0));
    for (int j = 1; j <= 13; j++)
      tk(mk($sformatf("t2.f%0d", j), 479 - 2 * j * (j - 1), -4 * j, 2, 2, 0));
    press();
    tk(mk("t2.f14", 115, -56, 2, 2, 0));
    tk(mk("t2.land", 102, 0, 0, 0, 1));
    tk(mk("t2.relaunch", 102, 40, 2, 1, 0));

    // fast-fall from apex with saturation
    for (int k = 1; k <= 10; k++)
      tk(mk($sformatf("t4.k%0d", k), rise_y(k), 40 - 4 * k, 2, 1, 0));
    lying = 1'b1;
    tk(mk("t4.v12", 322, -12, 2, 1, 0));
    tk(mk("t4.v24", 310, -24, 2, 1, 0));
    tk(mk("t4.v36", 286, -36, 2, 1, 0));
    tk(mk("t4.v48", 250, -48, 2, 1, 0));
    tk(mk("t4.v60", 202, -60, 2, 1, 0));
    tk(mk("t4.sat", 142, -60, 2, 1, 0));
    tk(mk("t4.land", 102, 0, 1, 0, 1));
    lying = 1'b0;
    tk(mk("t4.stand", 102, 0, 0, 0, 0));

    // jump beats duck, then Dead freezes mid-air
    lying = 1'b1;
    press();
    tk(mk("t5.launch", 102, 40, 2, 1, 0));
    lying = 1'b0;
    tk(mk("t5.air", 142, 36, 2, 1, 0));
    gamestate = 2'b10;
    tk(mk("t5.dead", 142, 36, 3, 1, 0));
    press();
    tk(mk("t5.dead2", 142, 36, 3, 1, 0));
    gamestate = 2'b00;
    tk(mk("t5.unbegin", 102, 0, 0, 0, 0));
    gamestate = 2'b01;
    tk(mk("t5.run", 102, 0, 0, 0, 0));

    // buffer cleared by UnBegin; same-clk edge; late edge
    gamestate = 2'b00;
    press();
    for (int i = 0; i < 4; i++)
      tk(mk($sformatf("t3.ub%0d", i), 102, 0, 0, 0, 0));
    gamestate = 2'b01;
    tk(mk("t3.expired", 102, 0, 0, 0, 0));
    jump = 1'b1;
    tk(mk("t3.same_clk", 102, 40, 2, 1, 0));
    jump = 1'b0;
    gamestate = 2'b11;
    tk(mk("t3.gs11", 102, 0, 0, 0, 0));
    press();
    gamestate = 2'b01;
    tk(mk("t3.late_edge", 102, 40, 2, 1, 0));
    tk(mk("t3.air", 142, 36, 2, 1, 0));

    // reset mid-air with tick held high
    rst  = 1'b1;
    tick = 1'b1;
    @(posedge clk);
    #1;
    chk("t6.rst.y", int'(dino_y), 102);
    chk("t6.rst.vel", int'(vel), 0);
    chk("t6.rst.pose", int'(pose), 0);
    chk("t6.rst.jumps", int'(jumps_used), 0);
    chk("t6.rst.landed", int'(landed), 0);
    @(negedge clk);
    tick = 1'b0;
    rst  = 1'b0;
    @(negedge clk);

    // ceiling clamp on the high-launch instance
    press();
    tk(mk("t6.launch", 102, 40, 2, 1, 0));
    chk("t6.c.y0", int'(dino_y1), 102);
    chk("t6.c.v0", int'(vel1), 200);
    chk("t6.c.pose", int'(pose1), 2);
    tk(mk("t6.k1", 142, 36, 2, 1, 0));
    chk("t6.c.y1", int'(dino_y1), 300);
    chk("t6.c.v1", int'(vel1), 0);
    tk(mk("t6.k2", 178, 32, 2, 1, 0));
    chk("t6.c.y2", int'(dino_y1), 300);
    chk("t6.c.v2", int'(vel1), -4);

    @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
